// File: rtl/multi_counter_if.sv
// Bundled control/status signals of the multi-channel counter.
// Channel i owns bit i of every per-channel vector and bits [i*WIDTH +: WIDTH] of limit/value.
interface multi_counter_if #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
);
    logic [NCH-1:0]       start;
    logic [NCH-1:0]       stop;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       mode;
    logic [NCH-1:0]       dir;
    logic [NCH*WIDTH-1:0] limit;
    logic [NCH*WIDTH-1:0] value;
    logic [NCH-1:0]       running;
    logic [NCH-1:0]       done;
    logic                 any_done;
    logic [2*NCH-1:0]     state_dbg;

    // Level-sampled control: every input is sampled on each rising clock edge.
    // There is no valid/ready pairing; a request is acted on for as long as it is held.
    modport master (
        output start, stop, en, mode, dir, limit,
        input  value, running, done, any_done, state_dbg
    );

    modport slave (
        input  start, stop, en, mode, dir, limit,
        output value, running, done, any_done, state_dbg
    );
endinterface

// File: rtl/multi_counter.sv
// NCH independent up/down counters with periodic or one-shot behaviour.
// Each channel steps through IDLE, RUN and HOLD. The terminal count tracks the live limit input.
module multi_counter #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4
) (
    input  logic           clk_a,
    input  logic           rst_n,
    multi_counter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [WIDTH-1:0] value_q [NCH];
    logic [WIDTH-1:0] value_d [NCH];
    logic [NCH-1:0]   mode_q, mode_d;
    logic [NCH-1:0]   dir_q, dir_d;
    logic [NCH-1:0]   done_q, done_d;
    logic             any_done_q, any_done_d;

    logic [WIDTH-1:0] lim    [NCH];
    logic [WIDTH-1:0] lim_m1 [NCH];
    logic [NCH-1:0]   term;

    // A limit of 0 is treated like 1, so a down reload and the up compare both use 0.
    always_comb begin
        term = '0;
        for (int i = 0; i < NCH; i++) begin
            lim[i]    = bus.limit[i*WIDTH +: WIDTH];
            lim_m1[i] = (lim[i] == '0) ? '0 : lim[i] - WIDTH'(1);
            term[i]   = dir_q[i] ? (value_q[i] == '0) : (value_q[i] >= lim_m1[i]);
        end
    end

    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        done_d = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            value_d[i] = value_q[i];
            if (bus.start[i]) begin
                state_d[i] = ST_RUN;
                mode_d[i]  = bus.mode[i];
                dir_d[i]   = bus.dir[i];
                value_d[i] = bus.dir[i] ? lim_m1[i] : '0;
            end else if (bus.stop[i]) begin
                state_d[i] = ST_IDLE;
                value_d[i] = '0;
            end else begin
                case (state_q[i])
                    ST_RUN: begin
                        if (bus.en[i]) begin
                            if (term[i]) begin
                                done_d[i] = 1'b1;
                                if (mode_q[i]) begin
                                    state_d[i] = ST_HOLD;
                                end else begin
                                    value_d[i] = dir_q[i] ? lim_m1[i] : '0;
                                end
                            end else begin
                                value_d[i] = dir_q[i] ? value_q[i] - WIDTH'(1)
                                                      : value_q[i] + WIDTH'(1);
                            end
                        end
                    end
                    ST_HOLD: state_d[i] = ST_HOLD;
                    default: begin
                        state_d[i] = ST_IDLE;
                        value_d[i] = '0;
                    end
                endcase
            end
        end
        any_done_d = |done_d;
    end

    always_ff @(posedge clk_a) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                value_q[i] <= '0;
            end
            mode_q     <= '0;
            dir_q      <= '0;
            done_q     <= '0;
            any_done_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                value_q[i] <= value_d[i];
            end
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            any_done_q <= any_done_d;
        end
    end

    logic [NCH*WIDTH-1:0] value_flat;
    logic [NCH-1:0]       running_flat;
    logic [2*NCH-1:0]     state_flat;

    always_comb begin
        value_flat   = '0;
        running_flat = '0;
        state_flat   = '0;
        for (int i = 0; i < NCH; i++) begin
            value_flat[i*WIDTH +: WIDTH] = value_q[i];
            running_flat[i]              = (state_q[i] == ST_RUN);
            state_flat[2*i +: 2]         = state_q[i];
        end
    end

    assign bus.value     = value_flat;
    assign bus.running   = running_flat;
    assign bus.done      = done_q;
    assign bus.any_done  = any_done_q;
    assign bus.state_dbg = state_flat;
endmodule

// File: tb/tb_multi_counter.sv
// Directed bench for multi_counter: a vector table on channel 0, then hand-written
// multi-cycle sequences for one-shot, enable gating, start/stop collisions and reset.
module tb_multi_counter;
    localparam int W = 8;
    localparam int N = 4;

    logic clk_a = 1'b0;
    logic rst_n;

    always #5 clk_a = ~clk_a;

    multi_counter_if #(.WIDTH(W), .NCH(N)) bus ();

    multi_counter #(.WIDTH(W), .NCH(N)) dut (
        .clk_a (clk_a),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic         start;
        logic         stop;
        logic         en;
        logic         mode;
        logic         dir;
        logic [W-1:0] limit;
        logic [W-1:0] exp_value;
        logic         exp_running;
        logic         exp_done;
    } vec_t;

    vec_t vecs [28];

    function automatic vec_t mk(input logic s, input logic sp, input logic e, input logic m,
                                input logic d, input int l, input int v, input logic r,
                                input logic dn);
        vec_t t;
        t.start = s; t.stop = sp; t.en = e; t.mode = m; t.dir = d;
        t.limit = W'(l); t.exp_value = W'(v); t.exp_running = r; t.exp_done = dn;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_a);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic s, input logic sp, input logic e,
                          input logic m, input logic d, input int l);
        bus.start[ch] = s;
        bus.stop[ch]  = sp;
        bus.en[ch]    = e;
        bus.mode[ch]  = m;
        bus.dir[ch]   = d;
        bus.limit[ch*W +: W] = W'(l);
    endtask

    task automatic clear_inputs();
        bus.start = '0;
        bus.stop  = '0;
        bus.en    = '0;
        bus.mode  = '0;
        bus.dir   = '0;
        bus.limit = '0;
    endtask

    function automatic int val(input int ch);
        return int'(bus.value[ch*W +: W]);
    endfunction

    task automatic check_ch(input string tag, input int ch, input int v, input logic r,
                            input logic dn);
        check({tag, " value"},   val(ch), v);
        check({tag, " running"}, int'(bus.running[ch]), int'(r));
        check({tag, " done"},    int'(bus.done[ch]), int'(dn));
        check({tag, " any_done"}, int'(bus.any_done), int'(dn));
    endtask

    initial begin
        //                 start stop en mode dir limit  value run done
        vecs[0]  = mk(1, 0, 0, 0, 0, 5,  0, 1, 0);
        vecs[1]  = mk(0, 0, 1, 0, 0, 5,  1, 1, 0);
        vecs[2]  = mk(0, 0, 1, 0, 0, 5,  2, 1, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 5,  3, 1, 0);
        vecs[4]  = mk(0, 0, 1, 0, 0, 5,  4, 1, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 5,  0, 1, 1);
        vecs[6]  = mk(0, 0, 1, 0, 0, 5,  1, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 5,  1, 1, 0);
        vecs[8]  = mk(0, 0, 1, 0, 0, 5,  2, 1, 0);
        vecs[9]  = mk(0, 0, 1, 0, 0, 10, 3, 1, 0);
        vecs[10] = mk(0, 0, 1, 0, 0, 10, 4, 1, 0);
        vecs[11] = mk(0, 0, 1, 0, 0, 10, 5, 1, 0);
        vecs[12] = mk(0, 0, 1, 0, 0, 10, 6, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 10, 7, 1, 0);
        vecs[14] = mk(0, 0, 1, 0, 0, 4,  0, 1, 1);
        vecs[15] = mk(0, 0, 1, 0, 0, 1,  0, 1, 1);
        vecs[16] = mk(0, 0, 1, 0, 0, 1,  0, 1, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 1,  0, 1, 0);
        vecs[18] = mk(0, 0, 1, 0, 0, 0,  0, 1, 1);
        vecs[19] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[20] = mk(0, 0, 1, 0, 0, 5,  0, 0, 0);
        vecs[21] = mk(1, 0, 0, 0, 1, 3,  2, 1, 0);
        vecs[22] = mk(0, 0, 1, 0, 0, 3,  1, 1, 0);
        vecs[23] = mk(0, 0, 1, 0, 0, 3,  0, 1, 0);
        vecs[24] = mk(0, 0, 1, 0, 0, 3,  2, 1, 1);
        vecs[25] = mk(0, 0, 1, 1, 0, 3,  1, 1, 0);
        vecs[26] = mk(0, 0, 1, 1, 0, 3,  0, 1, 0);
        vecs[27] = mk(0, 0, 1, 1, 0, 3,  2, 1, 1);

        // Reset state
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        for (int c = 0; c < N; c++) check_ch($sformatf("reset ch%0d", c), c, 0, 1'b0, 1'b0);
        check("reset state_dbg", int'(bus.state_dbg), 0);
        rst_n = 1'b1;

        // Channel 0 vector table
        for (int k = 0; k < 28; k++) begin
            set_ch(0, vecs[k].start, vecs[k].stop, vecs[k].en, vecs[k].mode, vecs[k].dir,
                   int'(vecs[k].limit));
            tick();
            check_ch($sformatf("vec%0d ch0", k), 0, int'(vecs[k].exp_value),
                     vecs[k].exp_running, vecs[k].exp_done);
        end
        clear_inputs();
        bus.stop = '1;
        tick();
        bus.stop = '0;

        // One-shot down, channel 1, limit 4
        set_ch(1, 1, 0, 0, 1, 1, 4);
        tick();
        check_ch("oneshot load", 1, 3, 1'b1, 1'b0);
        set_ch(1, 0, 0, 1, 0, 0, 4);
        for (int v = 2; v >= 0; v--) begin
            tick();
            check_ch($sformatf("oneshot v%0d", v), 1, v, 1'b1, 1'b0);
        end
        tick();
        check_ch("oneshot terminal", 1, 0, 1'b0, 1'b1);
        check("oneshot state_dbg hold", int'(bus.state_dbg[3:2]), 2);
        for (int k = 0; k < 4; k++) begin
            bus.en[1] = k[0];
            tick();
            check_ch($sformatf("oneshot hold%0d", k), 1, 0, 1'b0, 1'b0);
        end
        set_ch(1, 1, 0, 0, 1, 1, 4);
        tick();
        check_ch("oneshot restart", 1, 3, 1'b1, 1'b0);
        set_ch(1, 0, 1, 0, 0, 0, 4);
        tick();
        bus.stop[1] = 1'b0;

        // Enable gating then stop, channel 2
        set_ch(2, 1, 0, 0, 0, 0, 10);
        tick();
        check_ch("gate load", 2, 0, 1'b1, 1'b0);
        bus.start[2] = 1'b0;
        bus.en[2] = 1'b1; tick(); check_ch("gate en1a", 2, 1, 1'b1, 1'b0);
        bus.en[2] = 1'b0; tick(); check_ch("gate en0a", 2, 1, 1'b1, 1'b0);
        bus.en[2] = 1'b1; tick(); check_ch("gate en1b", 2, 2, 1'b1, 1'b0);
        bus.en[2] = 1'b0; tick(); check_ch("gate en0b", 2, 2, 1'b1, 1'b0);
        bus.stop[2] = 1'b1; tick(); check_ch("gate stop", 2, 0, 1'b0, 1'b0);
        bus.stop[2] = 1'b0;

        // Start and stop colliding with terminal, channel 3, limit 3
        set_ch(3, 1, 0, 0, 0, 0, 3);
        tick();
        bus.start[3] = 1'b0;
        bus.en[3] = 1'b1;
        tick(); check_ch("coll a1", 3, 1, 1'b1, 1'b0);
        tick(); check_ch("coll a2", 3, 2, 1'b1, 1'b0);
        bus.start[3] = 1'b1;
        tick(); check_ch("coll start", 3, 0, 1'b1, 1'b0);
        bus.start[3] = 1'b0;
        tick(); check_ch("coll b1", 3, 1, 1'b1, 1'b0);
        tick(); check_ch("coll b2", 3, 2, 1'b1, 1'b0);
        bus.stop[3] = 1'b1;
        tick(); check_ch("coll stop", 3, 0, 1'b0, 1'b0);
        clear_inputs();

        // Reset mid-count with start held on every channel
        for (int c = 0; c < N; c++) set_ch(c, 1, 0, 0, 0, 0, 5);
        tick();
        bus.start = '0;
        bus.en    = '1;
        for (int k = 0; k < 4; k++) tick();
        for (int c = 0; c < N; c++) check($sformatf("pre-reset ch%0d value", c), val(c), 4);
        bus.start = '1;
        rst_n = 1'b0;
        tick();
        for (int c = 0; c < N; c++) check_ch($sformatf("midreset ch%0d", c), c, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        bus.start = '0;
        tick();
        for (int c = 0; c < N; c++) check_ch($sformatf("postreset ch%0d", c), c, 0, 1'b0, 1'b0);
        bus.start = '1;
        tick();
        bus.start = '0;
        tick();
        for (int c = 0; c < N; c++) check_ch($sformatf("resume ch%0d", c), c, 1, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/multi_counter.md
MULTI_COUNTER -- requirements
Module: multi_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width per channel, range 2..32.
REQ-002 SHALL have parameter NCH, default 4: number of independent channels, range 1..16.
REQ-003 SHALL have port clk_a, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, NCH: per-channel start request, level sampled each edge.
REQ-006 SHALL have port stop, input, NCH: per-channel stop request.
REQ-007 SHALL have port en, input, NCH: per-channel count enable.
REQ-008 SHALL have port mode, input, NCH: 0 = periodic, 1 = one-shot; latched at start.
REQ-009 SHALL have port dir, input, NCH: 0 = up, 1 = down; latched at start.
REQ-010 SHALL have port limit, input, NCH*WIDTH: channel i in bits [i*WIDTH +: WIDTH]; read live, never latched.
REQ-011 SHALL have port value, output, NCH*WIDTH: registered count, channel i in bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port running, output, NCH: 1 while the channel is in RUN.
REQ-013 SHALL have port done, output, NCH: registered one-cycle terminal-count pulse.
REQ-014 SHALL have port any_done, output, 1: registered OR of the next-cycle done bits, so it is coincident with done.

Function
REQ-015 Each channel SHALL be independent, with states IDLE, RUN and HOLD.
REQ-016 Per-edge priority SHALL be: reset, then start, then stop, then counting.
REQ-017 On start, any state: go to RUN; latch mode and dir; load value to 0 if up, or to limit-1 if down; done stays 0 that cycle.
REQ-018 On stop without start: go to IDLE; value becomes 0; done becomes 0.
REQ-019 In RUN with en=0: value and state held; done becomes 0.
REQ-020 Terminal condition: up, value >= limit-1; down, value == 0.
REQ-021 In RUN with en=1 and no terminal: value +1 if up, -1 if down.
REQ-022 In RUN with en=1 and terminal: done becomes 1 on that edge, for exactly one cycle per terminal event.
REQ-023 At terminal, periodic: reload per the REQ-017 values using the current limit; stay in RUN.
REQ-024 At terminal, one-shot: hold value; go to HOLD; running becomes 0.
REQ-025 In HOLD: en is ignored; value is held; only start or stop leave HOLD.
REQ-026 In IDLE: value is 0; en is ignored.
REQ-027 limit of 0 or 1: value SHALL stay 0 and every enabled RUN cycle SHALL be terminal.
REQ-028 If limit is lowered below value+1 while counting up: terminal on the next enabled cycle (>= compare); no wrap through 2^WIDTH.
REQ-029 Arithmetic SHALL be modulo 2^WIDTH; limit-1 SHALL be computed at WIDTH bits, with limit=0 handled per REQ-027.
REQ-030 Simultaneous start and terminal: start wins, value reloads, no done pulse.
REQ-031 Simultaneous stop and terminal: stop wins, no done pulse.
REQ-032 Changing mode or dir during RUN SHALL have no effect until the next start.

Reset
REQ-033 With rst_n=0 at an edge, every channel SHALL go to IDLE with value=0, running=0, done=0, any_done=0, latched mode=0 and latched dir=0.
REQ-034 Reset SHALL override start, stop and en on the same edge.
REQ-035 Reset asserted mid-count SHALL clear state on that edge with no done pulse.
REQ-036 Outputs SHALL be undefined only before the first edge with rst_n=0.

Verification
REQ-037 Ch0 up, periodic, limit=5, en=1 after start: value 0,1,2,3,4,0,1...; done high the cycle value returns to 0; period 5 cycles.
REQ-038 Ch1 down, one-shot, limit=4: value 3,2,1,0, then holds 0; one done pulse; running=0; en toggling afterwards changes nothing; a new start reloads 3.
REQ-039 Ch2 up, en toggled 1,0,1,0: value advances only on en=1 cycles; stop at value=2 gives value=0 and running=0 next cycle.
REQ-040 Ch0 up counting at value=7, limit changed 10 -> 4: next enabled edge gives done=1 and value=0; limit=1 gives done every enabled cycle with value=0.
REQ-041 Start asserted on the terminal cycle of Ch3 (limit=3, up): value=0, no done pulse. Stop on the terminal cycle: no done pulse.
REQ-042 rst_n=0 for one edge while all NCH channels run with start=1: all value=0, running=0, done=0; counting resumes only after a fresh start.
